// File: rtl/uart_pkg.sv
// Shared UART definitions for TX and RX: data width, default baud divisor, FSM state encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS            = 8;
  localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 868;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count; sync clear restarts it.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned       CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  TERM  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: 8N1 framing, LSB first. Define UART_TX_PARITY_EN to add an even-parity bit.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx,
  output logic       o_tx_start_clear,
  output logic       o_tx_busy,
  output logic       o_txd
);

  localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

  uart_state_e                state_q, state_d;
  logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
  logic [2:0]                 idx_q, idx_d;
  logic                       txd_q, txd_d;
  logic                       busy_q, busy_d;
  logic                       clr_q, clr_d;
  logic                       tick;
  logic                       state_change;
`ifdef UART_TX_PARITY_EN
  logic                       parity_q, parity_d;
`endif

  assign state_change = (state_d != state_q);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear_i (state_change),
    .tick_o  (tick)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    clr_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_tx_start) begin
          shift_d  = i_tx;
          idx_d    = '0;
          clr_d    = 1'b1;
          state_d  = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^i_tx;
`endif
        end
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level is decoded from the next state so txd/busy come straight from flops.
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = parity_d;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      clr_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      clr_q    <= clr_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign o_txd            = txd_q;
  assign o_tx_busy        = busy_q;
  assign o_tx_start_clear = clr_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine at CLKS_PER_BIT=4; honours UART_TX_PARITY_EN.
module tb_uart_tx_engine;

  localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int unsigned FRAME_CYC = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_tx_start;
  logic [7:0] i_tx;
  logic       o_tx_start_clear;
  logic       o_tx_busy;
  logic       o_txd;

  int checks = 0;
  int errors = 0;

  uart_tx_engine #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_tx_start       (i_tx_start),
    .i_tx             (i_tx),
    .o_tx_start_clear (o_tx_start_clear),
    .o_tx_busy        (o_tx_busy),
    .o_txd            (o_txd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Expected line level k cycles after the frame starts: start, data LSB first, [parity], stop.
  function automatic logic line_at(input logic [7:0] b, input int unsigned k);
    int unsigned bit_no = k / CPB;
    int unsigned ones   = $countones(b);
    logic [10:0] w;
`ifdef UART_TX_PARITY_EN
    w = {1'b1, 1'(ones % 2), b, 1'b0};
`else
    w = {1'b0, 1'b1, b, 1'b0};
`endif
    return w[bit_no];
  endfunction

  task automatic check_idle_cycle(input string name);
    @(posedge clk); #1;
    checks++;
    if (o_txd !== 1'b1) begin
      errors++; $display("FAIL %s_txd: got %b expected 1", name, o_txd);
    end
    checks++;
    if (o_tx_busy !== 1'b0) begin
      errors++; $display("FAIL %s_busy: got %b expected 0", name, o_tx_busy);
    end
    checks++;
    if (o_tx_start_clear !== 1'b0) begin
      errors++; $display("FAIL %s_clear: got %b expected 0", name, o_tx_start_clear);
    end
  endtask

  task automatic start_request(input logic [7:0] b, input string name, output bit ok);
    int unsigned n = 0;
    ok = 1'b0;
    i_tx = b;
    i_tx_start = 1'b1;
    while (n < 50 && !ok) begin
      @(posedge clk); #1;
      n++;
      if (o_tx_start_clear === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_accept: clear=%b after 50 cycles, expected 1", name, o_tx_start_clear);
    end else begin
      checks++;
      if (n !== 1) begin
        errors++; $display("FAIL %s_latency: clear after %0d cycles, expected 1", name, n);
      end
    end
  endtask

  // Current sample point is the first START cycle. mode 0: drop request; 1: keep request with nxt; 2: mid-frame pulse.
  task automatic check_frame(input logic [7:0] b, input int mode, input logic [7:0] nxt, input string name);
    for (int unsigned k = 0; k < FRAME_CYC; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      checks++;
      if (o_txd !== line_at(b, k)) begin
        errors++; $display("FAIL %s_txd[%0d]: got %b expected %b (byte %h)", name, k, o_txd, line_at(b, k), b);
      end
      checks++;
      if (o_tx_busy !== 1'b1) begin
        errors++; $display("FAIL %s_busy[%0d]: got %b expected 1", name, k, o_tx_busy);
      end
      checks++;
      if (o_tx_start_clear !== (k == 0)) begin
        errors++; $display("FAIL %s_clear[%0d]: got %b expected %b", name, k, o_tx_start_clear, (k == 0));
      end
      if (k == 0) begin
        if (mode == 1) begin
          i_tx = nxt;
        end else begin
          i_tx_start = 1'b0;
          i_tx = ~b;
        end
      end
      if (mode == 2 && k == 13) begin
        i_tx_start = 1'b1;
        i_tx = 8'h00;
      end
      if (mode == 2 && k == 14) i_tx_start = 1'b0;
    end
  endtask

  task automatic send_and_check(input logic [7:0] b, input string name);
    bit ok;
    start_request(b, name, ok);
    if (ok) begin
      check_frame(b, 0, 8'h00, name);
      check_idle_cycle({name, "_after"});
    end else begin
      i_tx_start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", o_txd); end
    checks++;
    if (o_tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_tx_busy); end
    checks++;
    if (o_tx_start_clear !== 1'b0) begin errors++; $display("FAIL reset_clear: got %b expected 0", o_tx_start_clear); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_idle();
    for (int unsigned i = 0; i < 100; i++) check_idle_cycle("idle");
  endtask

  task automatic test_frame_a5();
    send_and_check(8'hA5, "a5");
  endtask

  task automatic test_parity();
    send_and_check(8'h07, "par07");
    send_and_check(8'h03, "par03");
  endtask

  task automatic test_ignore_midframe();
    bit ok;
    start_request(8'hC3, "c3", ok);
    if (ok) begin
      check_frame(8'hC3, 2, 8'h00, "c3");
      check_idle_cycle("c3_after");
    end
    i_tx_start = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    start_request(8'h55, "b2b55", ok);
    if (ok) begin
      check_frame(8'h55, 1, 8'hFF, "b2b55");
      check_idle_cycle("b2b_gap");
      @(posedge clk); #1;
      check_frame(8'hFF, 0, 8'h00, "b2bff");
      check_idle_cycle("b2bff_after");
    end
    i_tx_start = 1'b0;
  endtask

  task automatic test_reset_midframe();
    bit ok;
    start_request(8'hA6, "rstmid", ok);
    i_tx_start = 1'b0;
    if (ok) begin
      for (int unsigned k = 1; k <= 17; k++) begin
        @(posedge clk); #1;
      end
      checks++;
      if (o_txd !== line_at(8'hA6, 17)) begin
        errors++; $display("FAIL rstmid_bit3: got %b expected %b", o_txd, line_at(8'hA6, 17));
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (o_txd !== 1'b1) begin errors++; $display("FAIL rstmid_txd: got %b expected 1", o_txd); end
      checks++;
      if (o_tx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", o_tx_busy); end
      #1 rst = 1'b0;
      check_idle_cycle("rstmid_idle");
      send_and_check(8'h81, "post_rst81");
    end else begin
      rst = 1'b0;
    end
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 6; i++) begin
      logic [7:0] b;
      int unsigned gap;
      b = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 3);
      for (int unsigned g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
      send_and_check(b, "rand");
    end
  endtask

  initial begin
    rst = 1'b1;
    i_tx_start = 1'b0;
    i_tx = 8'h00;
    test_reset();
    test_idle();
    test_frame_a5();
    test_parity();
    test_ignore_midframe();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
